// File: rtl/ram_port_arbiter_pkg.sv
// Store/load flag encodings and arbiter FSM states shared by the RAM port.
package riscv_mem_pkg;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_SW   = 2'b01;
    localparam logic [1:0] WR_SH   = 2'b10;
    localparam logic [1:0] WR_SB   = 2'b11;

    localparam logic [2:0] LD_LW  = 3'b001;
    localparam logic [2:0] LD_LH  = 3'b110;
    localparam logic [2:0] LD_LB  = 3'b111;
    localparam logic [2:0] LD_LBU = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signals of the shared RAM port.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic [31:0]       d_addr;
    logic [1:0]        d_write_flag;
    logic [2:0]        d_load_flag;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_addr,
        input  d_write_flag, d_load_flag, d_wdata,
        input  ram_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output ram_en, ram_we, ram_be,
        output ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_addr,
        output d_write_flag, d_load_flag, d_wdata,
        output ram_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  ram_en, ram_we, ram_be,
        input  ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replication, load extraction/extension.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  wflag_i,
    input  logic [2:0]  lflag_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata_i[{off_i, 3'b000} +: 8];
        half_sel   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        be_o       = 4'hF;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
        misalign_o = 1'b0;
        case (wflag_i)
            WR_SW: misalign_o = off_i != 2'b00;
            WR_SH: begin
                be_o       = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = off_i[0];
            end
            WR_SB: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            default: begin
                // unlisted load codes fall through to a plain word load
                case (lflag_i)
                    LD_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
                    LD_LBU: rdata_o = {24'h0, byte_sel};
                    LD_LH: begin
                        rdata_o    = {{16{half_sel[15]}}, half_sel};
                        misalign_o = off_i[0];
                    end
                    LD_LHU: begin
                        rdata_o    = {16'h0, half_sel};
                        misalign_o = off_i[0];
                    end
                    default: misalign_o = off_i != 2'b00;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Fixed-priority IF/D arbiter for the single-port RAM with fixed-latency FSM.
// Optional MEM_MISALIGN_TRAP_EN: misaligned D accesses skip RAM, raise d_err.
module ram_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int RAM_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    ram_port_arbiter_if.slave bus
);
    arb_state_e        state_q;
    logic [2:0]        cnt_q;
    logic [2:0]        cnt_d;
    logic              fetch_q;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        wflag_q;
    logic [2:0]        lflag_q;
    logic [31:0]       wdata_q;

    logic        idle, issue, resp, store, trap;
    logic        if_rv, d_rv, misalign;
    logic [3:0]  be;
    logic [31:0] wdata_al, rdata_ext;
    logic        unused_bits;

    mem_lane_align u_align (
        .wflag_i    (wflag_q),
        .lflag_i    (lflag_q),
        .off_i      (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rdata_i    (bus.ram_rdata),
        .be_o       (be),
        .wdata_o    (wdata_al),
        .rdata_o    (rdata_ext),
        .misalign_o (misalign)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap    = misalign & ~fetch_q;
    assign bus.d_err = d_rv & trap;
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
    assign trap      = 1'b0;
    assign bus.d_err = 1'b0;
`endif

    assign unused_bits = ^{bus.if_addr[31:ADDR_W+2],
                           bus.if_addr[1:0],
                           bus.d_addr[31:ADDR_W+2]};

    assign idle  = state_q == ST_IDLE;
    assign issue = (state_q == ST_ISSUE) & ~trap;
    assign resp  = state_q == ST_RESP;
    assign store = wflag_q != WR_NONE;
    assign cnt_d = cnt_q - 3'd1;
    assign if_rv = resp & fetch_q;
    assign d_rv  = resp & ~fetch_q;

    assign bus.d_gnt     = bus.d_req & idle;
    assign bus.if_gnt    = bus.if_req & ~bus.d_req & idle;
    assign bus.ram_en    = issue;
    assign bus.ram_we    = issue & store;
    assign bus.ram_be    = issue ? be : 4'h0;
    assign bus.ram_addr  = issue ? addr_q[ADDR_W+1:2] : '0;
    assign bus.ram_wdata = issue ? wdata_al : '0;
    assign bus.if_rvalid = if_rv;
    assign bus.if_rdata  = if_rv ? bus.ram_rdata : '0;
    assign bus.d_rvalid  = d_rv;
    assign bus.d_rdata   = (d_rv & ~store & ~trap) ? rdata_ext : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fetch_q <= 1'b0;
            addr_q  <= '0;
            wflag_q <= '0;
            lflag_q <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.d_req) begin
                        state_q <= ST_ISSUE;
                        fetch_q <= 1'b0;
                        addr_q  <= bus.d_addr[ADDR_W+1:0];
                        wflag_q <= bus.d_write_flag;
                        lflag_q <= bus.d_load_flag;
                        wdata_q <= bus.d_wdata;
                    end else if (bus.if_req) begin
                        // fetch is always an aligned full-word read
                        state_q <= ST_ISSUE;
                        fetch_q <= 1'b1;
                        addr_q  <= {bus.if_addr[ADDR_W+1:2], 2'b00};
                        wflag_q <= WR_NONE;
                        lflag_q <= LD_LW;
                        wdata_q <= '0;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= 3'(RAM_LAT - 1);
                    state_q <= (trap || RAM_LAT == 1) ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == 3'd0) state_q <= ST_RESP;
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter (RAM_LAT=1 and RAM_LAT=3 instances).
module tb_ram_port_arbiter;
    import riscv_mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(12)) b1 ();
    ram_port_arbiter_if #(.ADDR_W(12)) b3 ();

    ram_port_arbiter #(.ADDR_W(12), .RAM_LAT(1)) u_lat1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );
    ram_port_arbiter #(.ADDR_W(12), .RAM_LAT(3)) u_lat3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.slave)
    );

    logic        if_req, d_req;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [1:0]  d_wf;
    logic [2:0]  d_lf;

    assign b1.if_req       = if_req & ~sel;
    assign b3.if_req       = if_req & sel;
    assign b1.d_req        = d_req & ~sel;
    assign b3.d_req        = d_req & sel;
    assign b1.if_addr      = if_addr;
    assign b3.if_addr      = if_addr;
    assign b1.d_addr       = d_addr;
    assign b3.d_addr       = d_addr;
    assign b1.d_write_flag = d_wf;
    assign b3.d_write_flag = d_wf;
    assign b1.d_load_flag  = d_lf;
    assign b3.d_load_flag  = d_lf;
    assign b1.d_wdata      = d_wdata;
    assign b3.d_wdata      = d_wdata;

    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [11:0] ram_addr;
    logic [31:0] if_rdata, d_rdata, ram_wdata;

    assign if_gnt    = sel ? b3.if_gnt    : b1.if_gnt;
    assign if_rvalid = sel ? b3.if_rvalid : b1.if_rvalid;
    assign if_rdata  = sel ? b3.if_rdata  : b1.if_rdata;
    assign d_gnt     = sel ? b3.d_gnt     : b1.d_gnt;
    assign d_rvalid  = sel ? b3.d_rvalid  : b1.d_rvalid;
    assign d_rdata   = sel ? b3.d_rdata   : b1.d_rdata;
    assign d_err     = sel ? b3.d_err     : b1.d_err;
    assign ram_en    = sel ? b3.ram_en    : b1.ram_en;
    assign ram_we    = sel ? b3.ram_we    : b1.ram_we;
    assign ram_be    = sel ? b3.ram_be    : b1.ram_be;
    assign ram_addr  = sel ? b3.ram_addr  : b1.ram_addr;
    assign ram_wdata = sel ? b3.ram_wdata : b1.ram_wdata;

    // RAM model: data valid only exactly RAM_LAT cycles after ram_en
    logic [31:0]      ram [0:255];
    logic [31:0]      shadow [0:255];
    logic             preload;
    logic             v1;
    logic [11:0]      a1;
    logic [2:0]       v3;
    logic [2:0][11:0] a3;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= shadow[i];
        end
        v1 <= b1.ram_en;
        if (b1.ram_en) a1 <= b1.ram_addr;
        v3 <= {v3[1:0], b3.ram_en};
        a3 <= {a3[1:0], b3.ram_addr};
        for (int i = 0; i < 4; i++) begin
            if (b1.ram_en && b1.ram_we && b1.ram_be[i])
                ram[b1.ram_addr[7:0]][8*i +: 8] <= b1.ram_wdata[8*i +: 8];
            if (b3.ram_en && b3.ram_we && b3.ram_be[i])
                ram[b3.ram_addr[7:0]][8*i +: 8] <= b3.ram_wdata[8*i +: 8];
        end
    end

    assign b1.ram_rdata = v1 ? ram[a1[7:0]] : 32'hDEAD_BEEF;
    assign b3.ram_rdata = v3[2] ? ram[a3[2][7:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {31'h0, |{if_gnt, if_rvalid, if_rdata, d_gnt,
                         d_rvalid, d_rdata, d_err, ram_en,
                         ram_we, ram_be, ram_addr, ram_wdata}};
    endfunction

    task automatic txn(input bit f, input logic [31:0] a,
                       input logic [1:0] wf, input logic [2:0] lf,
                       input logic [31:0] wd);
        int          wi, o, hs, cyc, lat;
        bit          st, trap;
        logic [31:0] w, exp, ewd;
        logic [3:0]  ebe;
        logic [7:0]  b;
        logic [15:0] h;
        lat  = sel ? 3 : 1;
        wi   = int'(a[9:2]);
        o    = int'(a[1:0]);
        hs   = a[1] ? 16 : 0;
        st   = !f && wf != 2'b00;
        trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (!f) begin
            if (wf == 2'b01) trap = o != 0;
            else if (wf == 2'b10) trap = a[0];
            else if (wf == 2'b11) trap = 1'b0;
            else if (lf == LD_LH || lf == LD_LHU) trap = a[0];
            else if (lf == LD_LB || lf == LD_LBU) trap = 1'b0;
            else trap = o != 0;
        end
`endif
        ebe = 4'hF;
        ewd = wd;
        if (wf == 2'b10) begin
            ebe = a[1] ? 4'hC : 4'h3;
            ewd = {2{wd[15:0]}};
        end else if (wf == 2'b11) begin
            ebe = 4'(1 << o);
            ewd = {4{wd[7:0]}};
        end
        w = shadow[wi];
        b = w[8*o +: 8];
        h = w[hs +: 16];
        exp = w;
        if (st) begin
            exp = '0;
            if (!trap) begin
                if (wf == 2'b01) shadow[wi] = wd;
                else if (wf == 2'b10) shadow[wi][hs +: 16] = wd[15:0];
                else shadow[wi][8*o +: 8] = wd[7:0];
            end
        end else if (!f) begin
            if (lf == LD_LB) exp = {{24{b[7]}}, b};
            else if (lf == LD_LBU) exp = {24'h0, b};
            else if (lf == LD_LH) exp = {{16{h[15]}}, h};
            else if (lf == LD_LHU) exp = {16'h0, h};
        end
        if (trap) exp = '0;

        @(negedge clk);
        if_req  = f;
        d_req   = !f;
        if_addr = a;
        d_addr  = a;
        d_wf    = wf;
        d_lf    = lf;
        d_wdata = wd;
        #1;
        chk("gnt", {31'h0, f ? if_gnt : d_gnt}, 1);
        @(negedge clk);
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("ram_en", {31'h0, ram_en}, {31'h0, !trap});
        if (!trap) begin
            chk("ram_addr", {20'h0, ram_addr}, {22'h0, a[11:2]});
            chk("ram_we", {31'h0, ram_we}, {31'h0, st});
            if (f || st) chk("ram_be", {28'h0, ram_be}, {28'h0, ebe});
            if (st) chk("ram_wdata", ram_wdata, ewd);
        end
        cyc = 1;
        while (!(f ? if_rvalid : d_rvalid) && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, trap ? 2 : 1 + lat);
        chk(f ? "if_rdata" : "d_rdata", f ? if_rdata : d_rdata, exp);
        chk("d_err", {31'h0, d_err}, {31'h0, trap});
    endtask

    logic [2:0] odd_lf [3] = '{3'b000, 3'b100, 3'b101};

    initial begin
        int          cyc, k, wi, seen;
        logic [1:0]  off;
        logic [31:0] a;
        rst = 1'b1; sel = 1'b0; preload = 1'b1;
        if_req = 1'b0; d_req = 1'b0;
        if_addr = '0; d_addr = '0; d_wf = '0; d_lf = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = $urandom;
        shadow[64] = 32'h80FF_7F01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs_l1", all_outs(), 0);
        sel = 1'b1;
        #1 chk("reset_outs_l3", all_outs(), 0);
        sel = 1'b0;
        rst = 1'b0; preload = 1'b0;

        txn(1, 32'h0000_0010, WR_NONE, LD_LW, 0);
        txn(0, 32'h0000_0013, WR_SB, LD_LW, 32'h0000_00A5);
        txn(0, 32'h0000_0012, WR_SH, LD_LW, 32'h1234_BEEF);
        txn(0, 32'h0000_0010, WR_NONE, LD_LW, 0);
        txn(0, 32'h0000_0103, WR_NONE, LD_LB, 0);
        txn(0, 32'h0000_0103, WR_NONE, LD_LBU, 0);
        txn(0, 32'h0000_0102, WR_NONE, LD_LH, 0);
        txn(0, 32'h0000_0100, WR_NONE, LD_LHU, 0);
        txn(0, 32'h0000_0102, WR_NONE, LD_LW, 0);
        txn(0, 32'h0000_0011, WR_SH, LD_LW, 32'h0000_5A5A);
        txn(0, 32'h0000_0010, WR_NONE, LD_LW, 0);

        // fixed priority: data wins, fetch waits for the next IDLE
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_addr = 32'h20; d_wf = WR_NONE; d_lf = LD_LW;
        #1;
        chk("prio_d_gnt", {31'h0, d_gnt}, 1);
        chk("prio_if_gnt", {31'h0, if_gnt}, 0);
        @(negedge clk);
        chk("busy_gnt", {30'h0, if_gnt, d_gnt}, 0);
        d_req = 1'b0;
        cyc = 1;
        while (!d_rvalid && cyc < 16) begin @(negedge clk); cyc++; end
        chk("prio_lat", cyc, 2);
        chk("prio_rdata", d_rdata, shadow[8]);
        chk("resp_if_gnt", {31'h0, if_gnt}, 0);
        @(negedge clk);
        chk("late_if_gnt", {31'h0, if_gnt}, 1);
        @(negedge clk);
        if_req = 1'b0;
        cyc = 1;
        while (!if_rvalid && cyc < 16) begin @(negedge clk); cyc++; end
        chk("late_if_lat", cyc, 2);
        chk("late_if_rdata", if_rdata, shadow[16]);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int n = 0; n < 60; n++) begin
                k   = $urandom_range(0, 9);
                wi  = $urandom_range(0, 63);
                off = 2'($urandom_range(0, 3));
                a   = 32'(wi * 4);
                unique case (k)
                    0: txn(1, a | {30'h0, off}, WR_NONE, LD_LW, 0);
                    1: txn(0, a, WR_SW, LD_LW, $urandom);
                    2: txn(0, a | {30'h0, off[1], 1'b0}, WR_SH, LD_LW, $urandom);
                    3: txn(0, a | {30'h0, off}, WR_SB, LD_LW, $urandom);
                    4: txn(0, a, WR_NONE, LD_LW, 0);
                    5: txn(0, a | {30'h0, off[1], 1'b0}, WR_NONE, LD_LH, 0);
                    6: txn(0, a | {30'h0, off}, WR_NONE, LD_LB, 0);
                    7: txn(0, a | {30'h0, off}, WR_NONE, LD_LBU, 0);
                    8: txn(0, a | {30'h0, off[1], 1'b0}, WR_NONE, LD_LHU, 0);
                    default: txn(0, a, WR_NONE, odd_lf[$urandom_range(0, 2)], 0);
                endcase
            end
        end

        // reset while the RAM_LAT=3 instance sits in WAIT
        sel = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h30; d_wf = WR_NONE; d_lf = LD_LW;
        @(negedge clk);
        d_req = 1'b0;
        chk("pre_rst_en", {31'h0, ram_en}, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outs", all_outs(), 0);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (d_rvalid || if_rvalid || ram_en) seen++;
        end
        chk("rst_no_resp", seen, 0);
        txn(0, 32'h0000_0030, WR_NONE, LD_LW, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port data/instruction RAM of the single-cycle core between two requesters: instruction fetch (IF) and load/store (D).
- D uses the decoder's store and load encodings (write_ram_flag, load_ram_flag).
- Sequences each access with a fixed-latency state machine.
- Generates byte strobes and store-data alignment, and sign/zero-extends load data.

Parameters:
- ADDR_W, 12, RAM word-address width (byte address bits [ADDR_W+1:2] are used).
- RAM_LAT, 1, cycles from the ram_en cycle until ram_rdata is valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address; word-aligned.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid; one-cycle pulse.
- if_rdata  out  32  fetch data.
- d_req  in  1  load/store request.
- d_addr  in  32  load/store byte address.
- d_write_flag  in  2  store encoding: 00 none, 01 sw, 10 sh, 11 sb.
- d_load_flag  in  3  load encoding: 001 lw, 110 lh, 111 lb, 011 lbu, 010 lhu.
- d_wdata  in  32  store data, right-justified.
- d_gnt  out  1  load/store request accepted this cycle.
- d_rvalid  out  1  load/store complete; one-cycle pulse.
- d_rdata  out  32  extended load data; 0 for stores.
- d_err  out  1  misaligned access; only with the optional feature.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write.
- ram_be  out  4  RAM byte enables.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  lane-aligned write data.
- ram_rdata  in  32  RAM read data.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset: state IDLE, latency counter 0, all outputs 0.
- Grants are issued only in IDLE. gnt is combinational: d_gnt = d_req & idle; if_gnt = if_req & ~d_req & idle. Data has fixed priority. Both gnt outputs are 0 in every other state.
- On the grant edge the block latches: requester id, address, write flag, load flag and wdata. Next state is ISSUE.
- ISSUE (exactly 1 cycle): ram_en=1 and ram_addr/ram_we/ram_be/ram_wdata driven from the latched values. Counter loads RAM_LAT-1. Next state is WAIT, or RESP if RAM_LAT=1.
- WAIT: counter decrements each cycle; moves to RESP when the counter reaches 0. ram_en=0.
- RESP (1 cycle): the granted requester's rvalid=1 and rdata is formatted combinationally from ram_rdata. Next state is IDLE.
- Latency: grant in cycle T gives rvalid in cycle T+1+RAM_LAT. Minimum request spacing is 2+RAM_LAT cycles.
- Request classification: store if d_write_flag != 00, otherwise load. A load with d_load_flag 000 or an unlisted code is treated as lw.
- Store lanes:
  - sw: be=1111.
  - sh: be=0011 if addr[1]=0, 1100 if addr[1]=1; half replicated into both halves.
  - sb: be=0001 shifted left by addr[1:0]; byte replicated into all four lanes.
- Load lanes: select the byte or half by addr[1:0] / addr[1]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Fetch: always a full-word read with be=1111 and ram_we=0. if_addr[1:0] is ignored.
- Stores: d_rvalid pulses in RESP with d_rdata=0.
- Outputs outside RESP: rdata outputs are 0 and rvalid outputs are 0.
- Requests must stay asserted until granted; the block never drops a requester's pending request by itself.
- Reset mid-operation (any state): return to IDLE next edge, drop the in-flight response, no rvalid pulse, no re-issue.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- When defined:
  - lw/sw with addr[1:0] != 0, or lh/lhu/sh with addr[0]=1, is still granted.
  - ISSUE asserts no ram_en; the FSM goes directly to RESP.
  - RESP pulses d_rvalid=1 and d_err=1, with d_rdata=0.
- When not defined:
  - d_err is tied 0.
  - Misaligned low address bits are forced to the natural alignment: addr[1:0] cleared for words, addr[0] cleared for halves.

Decomposition:
- Package riscv_mem_pkg holds:
  - the write_ram_flag codes (WR_NONE/WR_SW/WR_SH/WR_SB);
  - the load_ram_flag codes (LD_LW/LD_LH/LD_LB/LD_LBU/LD_LHU);
  - the FSM state enum.
- One combinational sub-module, mem_lane_align: inputs are flags, addr[1:0], wdata and ram_rdata; outputs are be, aligned wdata, extended rdata and misalign.

Test Plan:
- Fetch alone, RAM_LAT=1: if_req at 0x0000_0010 -> if_gnt cycle T, ram_en cycle T+1 with ram_addr=4 and be=1111, if_rvalid cycle T+2 with if_rdata = RAM word 4.
- Simultaneous if_req and d_req (lw 0x20) -> d_gnt=1, if_gnt=0; fetch granted in the first IDLE after d_rvalid.
- sb: d_wdata=0x000000A5, addr 0x...13 -> ram_be=1000, ram_wdata=0xA5A5A5A5; sh at addr 0x...12 -> be=1100.
- Loads of RAM word 0x80FF7F01: lb at +3 -> 0xFFFFFF80; lbu at +3 -> 0x00000080; lh at +2 -> 0xFFFF80FF; lhu at +0 -> 0x00007F01.
- RAM_LAT=3: rvalid exactly 4 cycles after grant. rst asserted in the WAIT state -> no rvalid, IDLE next cycle, all outputs 0.
- With MEM_MISALIGN_TRAP_EN, lw at 0x...02 -> no ram_en, d_rvalid=d_err=1 at T+2. Without the macro -> access to the aligned word and d_err=0.
